conv1_pool_writer: RTL and testbench
====================================

Name: conv1_pool_writer

Overview:
Downstream of the layer-1 PE. Consumes its raw conv1 output pixel stream, then applies lane-wise 2x2/stride-2 max-pool and ReLU. Writes the pooled words into the two ping-pong conv2 input banks (BRAMConv2Arr1/Arr2, port A). Owns bank full/release bookkeeping so the conv2 engine reads one bank while the other fills.

Parameters:
IMG_W, 28, conv1 output width in pixels; must be even
IMG_H, 28, conv1 output height in pixels; must be even
LANES, 8, channels packed per word
DW, 8, bits per lane, signed two's complement
ADDR_W, 12, bank address width

Ports:
clk  in  1  core clock (clk_wiz output)
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; when low, in_ready is forced low (no new pixels accepted)
in_valid  in  1  pixel word valid
in_ready  out  1  pixel word accepted when in_valid & in_ready
in_data  in  LANES*DW  one pixel, lane i at bits [i*DW +: DW]; row-major order
we_arr1  out  1  bank 0 write enable
we_arr2  out  1  bank 1 write enable
wr_addr  out  ADDR_W  write address, shared by both banks
wr_data  out  LANES*DW  pooled word, shared by both banks
bank_full  out  2  bit b set = bank b holds a complete pooled map
bank_release  in  2  1-cycle pulse from conv2 engine: bank b consumed
frame_done  out  1  1-cycle pulse when a bank becomes full
cur_bank  out  1  bank currently being filled

Behaviour:
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accept; col wraps to 0 and increments row; row wraps to 0 at end of frame.
- Even col: hreg <= in_data.
- Odd col: hmax = lane-wise signed max(hreg, in_data).
- Even row and odd col: linebuf[col>>1] <= hmax. linebuf holds IMG_W/2 words, implemented as registers.
- Odd row and odd col: pooled = lane-wise max(linebuf[col>>1], hmax); ReLU clamps each negative lane to 0.
  - Next cycle (latency 1, registered): we_arr{cur_bank+1}=1, wr_data=pooled, wr_addr=wcnt; then wcnt++.
  - Address sequence is 0 .. (IMG_W/2)*(IMG_H/2)-1 per frame, contiguous.
- Write-enable rules: at most one write per cycle; both we low otherwise; the inactive bank's we is never asserted.
- Frame completion: the cycle the last write (wcnt = N-1) is issued, the write completes. On the following edge: bank_full[cur_bank]<=1, frame_done=1 for one cycle, cur_bank toggles, wcnt<=0.
- in_ready = enable & ~bank_full[cur_bank] & (state==FILL).
- States:
  - FILL: pixels accepted. Goes to WAIT at the frame-end edge if bank_full[new cur_bank]=1.
  - WAIT: in_ready=0. Goes to FILL on the cycle after bank_full[cur_bank] clears.
- bank_release[b] clears bank_full[b] on the next edge.
  - Release of a bank not full: ignored.
  - Release and set of the same bank in the same cycle: set wins.
  - Releases of both banks in one cycle are allowed.
- enable dropping mid-frame: counters and linebuf hold; resume exactly where stopped.
- rst_n low (any time, including mid-frame) asynchronously clears all of the following: col, row, wcnt, hreg, state=FILL, cur_bank=0, bank_full=0, we_arr1/2=0, frame_done=0, wr_addr=0, wr_data=0. linebuf is not reset.
- Arithmetic: all compares signed DW-bit; no widening; ReLU output range 0..2^(DW-1)-1.

Decomposition:
- Shared package cnn_acc_pkg:
  - LANES and DW constants.
  - Packed pixel word typedef.
  - CONV2_BANK_WORDS = (IMG_W/2)*(IMG_H/2).
  - Lane-slicing function.
- One sub-module, lane_max: purely combinational, lane-wise signed max of two words with an optional relu input. Instantiated twice (horizontal, vertical+ReLU).

Test Plan:
- 4x4 image, IMG_W=IMG_H=4, lane0 = row*4+col, other lanes 0 -> bank0 writes: addr0=5, addr1=7, addr2=13, addr3=15; frame_done one cycle after addr3 write; bank_full=01; cur_bank=1.
- All lanes -3 except one pixel per 2x2 window with lane7 = -1 -> every wr_data is 0 (ReLU clamps).
- Three back-to-back 4x4 frames with no release:
  - frame 1 -> bank0 via we_arr1.
  - frame 2 -> bank1 via we_arr2.
  - in_ready then stays 0.
  - Pulse bank_release=01 -> in_ready=1 two cycles later; frame 3 writes bank0 from addr 0.
- in_valid toggling randomly and enable low for 5 cycles mid-row -> pooled values and address order identical to the uninterrupted run.
- rst_n asserted after 9 accepted pixels -> all outputs reset immediately. A clean frame afterwards produces writes at addr 0..3 into bank0 only.
- bank_release=01 in the same cycle bank0 becomes full -> bank_full[0] remains 1; a release in a later cycle clears it.

Source files
------------

// File: rtl/cnn_acc_pkg.sv
`default_nettype none
// ==== cnn_acc_pkg : shared CNN accelerator types, constants and lane helpers ====
// ==== rev 1.0                                                              ====
package cnn_acc_pkg;

  localparam int LANES            = 8;
  localparam int DW               = 8;
  localparam int CONV1_IMG_W      = 28;
  localparam int CONV1_IMG_H      = 28;
  localparam int CONV2_BANK_WORDS = (CONV1_IMG_W / 2) * (CONV1_IMG_H / 2);

  typedef logic [LANES*DW-1:0]  pixel_t;
  typedef logic signed [DW-1:0] lane_t;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_WAIT = 1'b1
  } wr_state_e;

  function automatic lane_t lane_of(input pixel_t w, input int unsigned idx);
    return $signed(w[idx*DW +: DW]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_max.sv
`default_nettype none
// ==== lane_max : lane-wise signed max of two pixel words, optional ReLU ====
// ==== rev 1.0                                                          ====
module lane_max
  import cnn_acc_pkg::*;
(
  input  pixel_t i_a,
  input  pixel_t i_b,
  input  logic   i_relu,
  output pixel_t o_y
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_t w_la;
    lane_t w_lb;
    lane_t w_max;

    assign w_la  = lane_of(i_a, i);
    assign w_lb  = lane_of(i_b, i);
    assign w_max = (w_la > w_lb) ? w_la : w_lb;
    assign o_y[i*DW +: DW] = (i_relu && w_max[DW-1]) ? '0 : w_max;
  end

endmodule
`default_nettype wire

// File: rtl/conv1_pool_writer.sv
`default_nettype none
// ==== conv1_pool_writer : 2x2 max-pool + ReLU of conv1 pixels into ping-pong ====
// ==== conv2 input banks, with bank full/release bookkeeping.  rev 1.0        ====
module conv1_pool_writer
  import cnn_acc_pkg::wr_state_e;
  import cnn_acc_pkg::ST_FILL;
  import cnn_acc_pkg::ST_WAIT;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int LANES  = 8,
  parameter int DW     = 8,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  output logic                we_arr1,
  output logic                we_arr2,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [LANES*DW-1:0] wr_data,
  output logic [1:0]          bank_full,
  input  logic [1:0]          bank_release,
  output logic                frame_done,
  output logic                cur_bank
);

  localparam int C_PW     = LANES * DW;
  localparam int C_COL_W  = $clog2(IMG_W);
  localparam int C_ROW_W  = $clog2(IMG_H);
  localparam int C_HALF_W = IMG_W / 2;
  localparam int C_WORDS  = (IMG_W / 2) * (IMG_H / 2);

  localparam logic [C_COL_W-1:0] C_COL_LAST  = C_COL_W'(IMG_W - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST  = C_ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]  C_ADDR_LAST = ADDR_W'(C_WORDS - 1);

  logic [C_COL_W-1:0] col_q, col_d;
  logic [C_ROW_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
  logic [C_PW-1:0]    hreg_q, hreg_d;
  wr_state_e          state_q, state_d;
  logic               cur_bank_q, cur_bank_d;
  logic [1:0]         bank_full_q, bank_full_d;
  logic               we1_q, we1_d;
  logic               we2_q, we2_d;
  logic               frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [C_PW-1:0]    wr_data_q, wr_data_d;

  // Half-row of horizontal maxima from the even row, consumed by the odd row.
  logic [C_PW-1:0]    linebuf_q [C_HALF_W];

  logic               w_accept;
  logic               w_pool_fire;
  logic               w_lb_we;
  logic               w_last_wr;
  logic [C_COL_W-2:0] w_lb_idx;
  logic [C_PW-1:0]    w_lb_rd;
  logic [C_PW-1:0]    w_hmax;
  logic [C_PW-1:0]    w_pooled;

  assign in_ready    = enable & ~bank_full_q[cur_bank_q] & (state_q == ST_FILL);
  assign w_accept    = in_valid & in_ready;
  assign w_lb_idx    = col_q[C_COL_W-1:1];
  assign w_lb_rd     = linebuf_q[w_lb_idx];
  assign w_lb_we     = w_accept & ~row_q[0] & col_q[0];
  assign w_pool_fire = w_accept &  row_q[0] & col_q[0];
  assign w_last_wr   = (we1_q | we2_q) & (wr_addr_q == C_ADDR_LAST);

  lane_max u_hmax (
    .i_a    (hreg_q),
    .i_b    (in_data),
    .i_relu (1'b0),
    .o_y    (w_hmax)
  );

  lane_max u_vmax (
    .i_a    (w_lb_rd),
    .i_b    (w_hmax),
    .i_relu (1'b1),
    .o_y    (w_pooled)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    wcnt_d       = wcnt_q;
    hreg_d       = hreg_q;
    state_d      = state_q;
    cur_bank_d   = cur_bank_q;
    bank_full_d  = bank_full_q & ~bank_release;
    we1_d        = 1'b0;
    we2_d        = 1'b0;
    frame_done_d = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (w_accept) begin
      if (!col_q[0]) hreg_d = in_data;
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (w_pool_fire) begin
      we1_d     = ~cur_bank_q;
      we2_d     =  cur_bank_q;
      wr_addr_d = wcnt_q;
      wr_data_d = w_pooled;
      wcnt_d    = wcnt_q + 1'b1;
    end

    // The last pixel of a frame is never followed by a pool in the same
    // cycle, so the frame-end bookkeeping cannot collide with a new write.
    if (w_last_wr) begin
      bank_full_d[cur_bank_q] = 1'b1;
      frame_done_d            = 1'b1;
      cur_bank_d              = ~cur_bank_q;
      wcnt_d                  = '0;
    end

    case (state_q)
      ST_FILL: if (w_last_wr && bank_full_d[cur_bank_d]) state_d = ST_WAIT;
      ST_WAIT: if (!bank_full_q[cur_bank_q])              state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      wcnt_q       <= '0;
      hreg_q       <= '0;
      state_q      <= ST_FILL;
      cur_bank_q   <= 1'b0;
      bank_full_q  <= '0;
      we1_q        <= 1'b0;
      we2_q        <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      wcnt_q       <= wcnt_d;
      hreg_q       <= hreg_d;
      state_q      <= state_d;
      cur_bank_q   <= cur_bank_d;
      bank_full_q  <= bank_full_d;
      we1_q        <= we1_d;
      we2_q        <= we2_d;
      frame_done_q <= frame_done_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_lb_we) linebuf_q[w_lb_idx] <= w_hmax;
  end

  assign we_arr1    = we1_q;
  assign we_arr2    = we2_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign bank_full  = bank_full_q;
  assign frame_done = frame_done_q;
  assign cur_bank   = cur_bank_q;

endmodule
`default_nettype wire

// File: tb/tb_conv1_pool_writer.sv
`default_nettype none
// ==== tb_conv1_pool_writer : scoreboard bench for conv1_pool_writer on a 4x4 map ====
// ==== rev 1.0                                                                  ====
module tb_conv1_pool_writer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int LN = 8;
  localparam int D  = 8;
  localparam int AW = 12;
  localparam int NW = (W / 2) * (H / 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          we_arr1;
  logic          we_arr2;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [1:0]    bank_full;
  logic [1:0]    bank_release;
  logic          frame_done;
  logic          cur_bank;

  conv1_pool_writer #(
    .IMG_W(W), .IMG_H(H), .LANES(LN), .DW(D), .ADDR_W(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .we_arr1      (we_arr1),
    .we_arr2      (we_arr2),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .bank_full    (bank_full),
    .bank_release (bank_release),
    .frame_done   (frame_done),
    .cur_bank     (cur_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    int          addr;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pix [H][W][LN];
  int   m_cur;
  bit   m_full [2];
  bit   prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every presented write is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (frame_done || prev_last) check("frame_done", 64'(frame_done), 64'(prev_last));
      if (we_arr1 || we_arr2) begin
        check("we_exclusive", 64'(we_arr1 & we_arr2), 64'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got write at addr %0d, expected none", wr_addr);
        end else begin
          e = sb.pop_front();
          check("wr_bank", 64'(we_arr2), 64'(e.bank));
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", wr_data, e.data);
        end
        prev_last = (int'(wr_addr) == NW - 1);
      end else begin
        prev_last = 1'b0;
      end
    end
  end

  function automatic logic [63:0] pack(input int r, input int c);
    logic [63:0] p;
    int v;
    p = '0;
    for (int l = 0; l < LN; l++) begin
      v = pix[r][c][l];
      p[l*D +: D] = v[D-1:0];
    end
    return p;
  endfunction

  function automatic logic [63:0] model_win(input int wr, input int wc);
    logic [63:0] res;
    int m;
    res = '0;
    for (int l = 0; l < LN; l++) begin
      m = -1000;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (pix[2*wr+dr][2*wc+dc][l] > m) m = pix[2*wr+dr][2*wc+dc][l];
      if (m < 0) m = 0;
      res[l*D +: D] = m[D-1:0];
    end
    return res;
  endfunction

  task automatic push_expected(input int npix);
    exp_t e;
    int a;
    a = 0;
    for (int wr = 0; wr < H / 2; wr++)
      for (int wc = 0; wc < W / 2; wc++)
        if ((2*wr+1)*W + 2*wc + 1 < npix) begin
          e.bank = m_cur;
          e.addr = a;
          e.data = model_win(wr, wc);
          sb.push_back(e);
          a++;
        end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int l = 0; l < LN; l++) pix[r][c][l] = (l == 0) ? r*W + c : 0;
  endtask

  task automatic fill_neg();
    int pr, pc;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int l = 0; l < LN; l++) pix[r][c][l] = -3;
    for (int wr = 0; wr < H / 2; wr++)
      for (int wc = 0; wc < W / 2; wc++) begin
        pr = 2*wr + int'($urandom_range(0, 1));
        pc = 2*wc + int'($urandom_range(0, 1));
        pix[pr][pc][7] = -1;
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int l = 0; l < LN; l++) pix[r][c][l] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic send_pixel(input logic [63:0] d, input bit gaps);
    int t;
    bit ok;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no in_ready in 200 cycles, expected acceptance");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int npix, input bit gaps, input bit en_drop);
    push_expected(npix);
    for (int p = 0; p < npix; p++) begin
      if (en_drop && p == 6) begin
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = pack(p / W, p % W);
        repeat (5) begin
          @(negedge clk);
          check("in_ready_enable_low", 64'(in_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        enable = 1'b1;
      end
      send_pixel(pack(p / W, p % W), gaps);
    end
    if (npix == W * H) begin
      m_full[m_cur] = 1'b1;
      m_cur ^= 1;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_banks();
    check("bank_full", 64'(bank_full), 64'({m_full[1], m_full[0]}));
    check("cur_bank", 64'(cur_bank), 64'(m_cur));
  endtask

  task automatic do_release(input logic [1:0] b);
    bank_release = b;
    @(posedge clk);
    #1;
    bank_release = 2'b00;
    if (b[0]) m_full[0] = 1'b0;
    if (b[1]) m_full[1] = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_we_arr1", 64'(we_arr1), 64'd0);
    check("rst_we_arr2", 64'(we_arr2), 64'd0);
    check("rst_bank_full", 64'(bank_full), 64'd0);
    check("rst_cur_bank", 64'(cur_bank), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n        = 1'b0;
    enable       = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    bank_release = 2'b00;
    m_cur        = 0;
    m_full[0]    = 1'b0;
    m_full[1]    = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame into bank 0, then all-negative frame into bank 1 (ReLU to 0).
    fill_ramp();
    send_frame(W * H, 1'b0, 1'b0);
    fill_neg();
    send_frame(W * H, 1'b0, 1'b0);
    wait_drain();
    check_banks();

    // Both banks full: intake stalls until bank 0 is released.
    repeat (4) begin
      @(negedge clk);
      check("in_ready_both_full", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    do_release(2'b01);
    @(negedge clk);
    check("in_ready_release_plus1", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("in_ready_release_plus2", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    fill_rand();
    send_frame(W * H, 1'b0, 1'b0);
    wait_drain();
    check_banks();

    // Release both banks at once, then an interrupted frame into bank 1.
    do_release(2'b11);
    check_banks();
    fill_rand();
    send_frame(W * H, 1'b1, 1'b1);
    wait_drain();
    check_banks();

    // Release of bank 0 in the very cycle it becomes full: full must stick.
    fill_rand();
    send_frame(W * H, 1'b0, 1'b0);
    t = 0;
    while (!(we_arr1 && int'(wr_addr) == NW - 1) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    bank_release = 2'b01;
    @(posedge clk);
    #1;
    bank_release = 2'b00;
    wait_drain();
    check_banks();
    do_release(2'b01);
    check_banks();
    do_release(2'b10);
    check_banks();

    // Partial frame, then asynchronous reset mid-frame.
    fill_rand();
    send_frame(9, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_drain", 64'(sb.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    m_cur     = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_ramp();
    send_frame(W * H, 1'b1, 1'b0);
    wait_drain();
    check_banks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
